// File: rtl/adder_fault_scan.sv
// adder_fault_scan: ripple-carry adder with a built-in slice scan.
// Direct mode runs one add; scan mode sweeps every slice through all
// eight (a, b, carry-in) cases and locates the first failing slice.
// Params: WIDTH operand bits, FAULT_BIT faulty slice index.
// Macro FAULT_INJECT_EN swaps slice FAULT_BIT for a faulty model.
// Ports:
//   clk, rst(async high), start, mode(0 direct/1 scan), a, b, cin
//   busy, done, sum, mismatch, fault_idx, fail_vec, fail_count
module adder_fault_scan #(
    parameter int WIDTH     = 8,
    parameter int FAULT_BIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mode,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         cin,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH:0]               sum,
    output logic                         mismatch,
    output logic [$clog2(WIDTH)-1:0]     fault_idx,
    output logic [$clog2(8*WIDTH)-1:0]   fail_vec,
    output logic [$clog2(8*WIDTH+1)-1:0] fail_count
);

    localparam int NV = 8 * WIDTH;
    localparam int IW = $clog2(WIDTH);
    localparam int VW = $clog2(NV);
    localparam int CW = $clog2(NV + 1);

`ifdef FAULT_INJECT_EN
    localparam bit FI = 1'b1;
`else
    localparam bit FI = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        DIRECT,
        SCAN,
        FLUSH,
        DONE
    } state_t;

    state_t state;
    state_t nxt;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rcin;
    logic [VW-1:0]    k;

    // One-deep compare pipeline between vector apply and bookkeeping.
    logic             p_valid;
    logic [WIDTH:0]   p_diff;
    logic [VW-1:0]    p_k;

    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vcin;
    logic [IW-1:0]    bi;

    logic [WIDTH-1:0] s;
    logic             carry;
    logic [WIDTH:0]   dut;
    logic [WIDTH:0]   golden;
    logic [WIDTH:0]   diff;

    function automatic logic [IW-1:0] lowbit(input logic [WIDTH:0] d);
        logic [IW-1:0] r;
        r = '0;
        for (int j = WIDTH; j >= 0; j--) begin
            if (d[j]) r = IW'(j);
        end
        return r;
    endfunction

    // Operand source: latched operands, or the scan pattern for vector k.
    // For slices above 0 the carry-in is produced by a generate pair
    // in the slice just below.
    always_comb begin
        bi   = k[VW-1:3];
        va   = ra;
        vb   = rb;
        vcin = rcin;
        if (state == SCAN) begin
            va     = '0;
            vb     = '0;
            vcin   = 1'b0;
            va[bi] = k[0];
            vb[bi] = k[1];
            if (bi == '0) begin
                vcin = k[2];
            end else begin
                va[bi - IW'(1)] = k[2];
                vb[bi - IW'(1)] = k[2];
            end
        end
    end

    // Slice chain. The faulty slice drops carry-in from its sum only.
    always_comb begin
        carry = vcin;
        s     = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (FI && j == FAULT_BIT)
                s[j] = va[j] ^ vb[j];
            else
                s[j] = va[j] ^ vb[j] ^ carry;
            carry = (va[j] & vb[j]) | (carry & (va[j] ^ vb[j]));
        end
        dut = {carry, s};
    end

    assign golden = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vcin};
    assign diff   = dut ^ golden;

    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (start) nxt = mode ? SCAN : DIRECT;
            end
            DIRECT: begin
                busy = 1'b1;
                nxt  = DONE;
            end
            SCAN: begin
                busy = 1'b1;
                if (k == VW'(NV - 1)) nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                nxt  = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ra         <= '0;
            rb         <= '0;
            rcin       <= 1'b0;
            k          <= '0;
            p_valid    <= 1'b0;
            p_diff     <= '0;
            p_k        <= '0;
            sum        <= '0;
            mismatch   <= 1'b0;
            fault_idx  <= '0;
            fail_vec   <= '0;
            fail_count <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra         <= a;
                        rb         <= b;
                        rcin       <= cin;
                        k          <= '0;
                        p_valid    <= 1'b0;
                        mismatch   <= 1'b0;
                        fault_idx  <= '0;
                        fail_vec   <= '0;
                        fail_count <= '0;
                    end
                end
                DIRECT: begin
                    sum        <= dut;
                    mismatch   <= |diff;
                    fault_idx  <= lowbit(diff);
                    fail_count <= CW'(|diff);
                end
                SCAN, FLUSH: begin
                    if (state == SCAN) begin
                        sum     <= dut;
                        p_valid <= 1'b1;
                        p_diff  <= diff;
                        p_k     <= k;
                        k       <= k + VW'(1);
                    end else begin
                        p_valid <= 1'b0;
                    end
                    // Bookkeeping for the vector applied last cycle.
                    if (p_valid && |p_diff) begin
                        if (fail_count != CW'(NV))
                            fail_count <= fail_count + CW'(1);
                        if (!mismatch) begin
                            mismatch  <= 1'b1;
                            fault_idx <= lowbit(p_diff);
                            fail_vec  <= p_k;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_fault_scan.sv
// tb_adder_fault_scan: vector table, random direct adds and scans
// checked against an arithmetic reference model.
module tb_adder_fault_scan;

`ifdef FAULT_INJECT_EN
    localparam bit FI = 1'b1;
    localparam int S8_CNT = 8;
    localparam int S8_VEC = 27;
    localparam int S8_IDX = 4;
`else
    localparam bit FI = 1'b0;
    localparam int S8_CNT = 0;
    localparam int S8_VEC = 0;
    localparam int S8_IDX = 0;
`endif
    localparam int FB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, mode8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, mis8;
    logic [8:0] sum8;
    logic [2:0] fidx8;
    logic [5:0] fvec8;
    logic [6:0] fcnt8;

    logic        start16, mode16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, mis16;
    logic [16:0] sum16;
    logic [3:0]  fidx16;
    logic [6:0]  fvec16;
    logic [7:0]  fcnt16;

    adder_fault_scan #(.WIDTH(8), .FAULT_BIT(FB)) u8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
        .sum(sum8), .mismatch(mis8), .fault_idx(fidx8),
        .fail_vec(fvec8), .fail_count(fcnt8)
    );

    adder_fault_scan #(.WIDTH(16), .FAULT_BIT(FB)) u16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16),
        .a(a16), .b(b16), .cin(cin16), .busy(busy16), .done(done16),
        .sum(sum16), .mismatch(mis16), .fault_idx(fidx16),
        .fail_vec(fvec16), .fail_count(fcnt16)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Adder output as the slice chain should produce it. With the fault
    // compiled in, sum bit FB loses its carry-in contribution.
    function automatic logic [16:0] model_dut(input int w,
            input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] g;
        int cf;
        g = 17'(x) + 17'(y) + 17'(c);
        if (FI && FB < w) begin
            cf = ((int'(x) % (1 << FB)) + (int'(y) % (1 << FB))
                  + int'(c)) / (1 << FB);
            if (cf != 0) g[FB] = ~g[FB];
        end
        return g;
    endfunction

    function automatic int model_lsb(input logic [16:0] d);
        for (int j = 0; j < 17; j++) if (d[j]) return j;
        return 0;
    endfunction

    task automatic scan_model(input int w, output int cnt,
            output int first, output int fidx, output logic [16:0] last);
        int i, r, av, bv, cv, c;
        logic [16:0] got, gold, d;
        cnt = 0; first = 0; fidx = 0; last = '0;
        for (int kk = 0; kk < 8 * w; kk++) begin
            i  = kk / 8;
            r  = kk % 8;
            c  = r / 4;
            av = (r % 2) << i;
            bv = ((r / 2) % 2) << i;
            cv = c;
            if (i > 0) begin
                av = av + (c << (i - 1));
                bv = bv + (c << (i - 1));
                cv = 0;
            end
            got  = model_dut(w, 16'(av), 16'(bv), cv[0]);
            gold = 17'(av + bv + cv);
            d    = got ^ gold;
            if (d != 0) begin
                if (cnt == 0) begin
                    first = kk;
                    fidx  = model_lsb(d);
                end
                cnt++;
            end
            last = got;
        end
    endtask

    task automatic run8(input logic md, input logic [7:0] av,
            input logic [7:0] bv, input logic cv,
            output int lat, output int bcnt);
        @(negedge clk);
        start8 = 1'b1; mode8 = md; a8 = av; b8 = bv; cin8 = cv;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (busy8) bcnt++;
            if (done8) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run16_scan(output int lat);
        @(negedge clk);
        start16 = 1'b1; mode16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
        @(posedge clk);
        #1 start16 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (done16) begin
                lat = n;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] sum;
        logic       mis;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int lat, bc, cnt, first, fidx, dmask;
        logic [16:0] last, e, g;
        logic [7:0] ra, rb;
        logic rc;

        tbl[0] = '{8'd200, 8'd100, 1'b1, 9'd301, 1'b0, 3'd0};
        tbl[3] = '{8'd0,   8'd0,   1'b0, 9'd0,   1'b0, 3'd0};
        tbl[6] = '{8'd3,   8'd4,   1'b0, 9'd7,   1'b0, 3'd0};
`ifdef FAULT_INJECT_EN
        tbl[1] = '{8'd8,   8'd8,   1'b0, 9'd0,   1'b1, 3'd4};
        tbl[2] = '{8'd255, 8'd255, 1'b1, 9'd495, 1'b1, 3'd4};
        tbl[4] = '{8'd15,  8'd1,   1'b0, 9'd0,   1'b1, 3'd4};
        tbl[5] = '{8'd255, 8'd1,   1'b0, 9'd272, 1'b1, 3'd4};
`else
        tbl[1] = '{8'd8,   8'd8,   1'b0, 9'd16,  1'b0, 3'd0};
        tbl[2] = '{8'd255, 8'd255, 1'b1, 9'd511, 1'b0, 3'd0};
        tbl[4] = '{8'd15,  8'd1,   1'b0, 9'd16,  1'b0, 3'd0};
        tbl[5] = '{8'd255, 8'd1,   1'b0, 9'd256, 1'b0, 3'd0};
`endif

        rst = 1'b1;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start16 = 0; mode16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_sum", 32'(sum8), 0);
        chk("rst_mis", 32'(mis8), 0);
        chk("rst_fcnt", 32'(fcnt8), 0);

        for (int t = 0; t < 7; t++) begin
            run8(1'b0, tbl[t].a, tbl[t].b, tbl[t].cin, lat, bc);
            chk($sformatf("tbl%0d_lat", t), 32'(lat), 2);
            chk($sformatf("tbl%0d_busy", t), 32'(bc), 1);
            chk($sformatf("tbl%0d_sum", t), 32'(sum8), 32'(tbl[t].sum));
            chk($sformatf("tbl%0d_mis", t), 32'(mis8), 32'(tbl[t].mis));
            chk($sformatf("tbl%0d_idx", t), 32'(fidx8), 32'(tbl[t].idx));
        end

        for (int t = 0; t < 20; t++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            e  = model_dut(8, {8'b0, ra}, {8'b0, rb}, rc);
            g  = 17'(ra) + 17'(rb) + 17'(rc);
            run8(1'b0, ra, rb, rc, lat, bc);
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 2);
            chk($sformatf("rnd%0d_sum", t), 32'(sum8), 32'(e));
            chk($sformatf("rnd%0d_mis", t), 32'(mis8), 32'(e != g));
            chk($sformatf("rnd%0d_idx", t), 32'(fidx8),
                32'(model_lsb(e ^ g)));
        end

        scan_model(8, cnt, first, fidx, last);
        run8(1'b1, 8'd0, 8'd0, 1'b0, lat, bc);
        chk("scan8_lat", 32'(lat), 66);
        chk("scan8_busy", 32'(bc), 65);
        chk("scan8_cnt", 32'(fcnt8), 32'(S8_CNT));
        chk("scan8_vec", 32'(fvec8), 32'(S8_VEC));
        chk("scan8_idx", 32'(fidx8), 32'(S8_IDX));
        chk("scan8_mis", 32'(mis8), 32'(S8_CNT != 0));
        chk("scan8_sum", 32'(sum8), 32'(last));

        @(negedge clk);
        chk("after_done_busy", 32'(busy8), 0);
        chk("after_done_done", 32'(done8), 0);
        chk("hold_cnt", 32'(fcnt8), 32'(S8_CNT));

        scan_model(16, cnt, first, fidx, last);
        run16_scan(lat);
        chk("scan16_lat", 32'(lat), 130);
        chk("scan16_cnt", 32'(fcnt16), 32'(cnt));
        chk("scan16_mis", 32'(mis16), 32'(cnt != 0));
        chk("scan16_vec", 32'(fvec16), 32'(first));
        chk("scan16_idx", 32'(fidx16), 32'(fidx));
        chk("scan16_sum", 32'(sum16), 32'(last));

        // Reset in the middle of a scan.
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy_before", 32'(busy8), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy8), 0);
        chk("mid_rst_done", 32'(done8), 0);
        chk("mid_rst_sum", 32'(sum8), 0);
        chk("mid_rst_mis", 32'(mis8), 0);
        chk("mid_rst_idx", 32'(fidx8), 0);
        chk("mid_rst_vec", 32'(fvec8), 0);
        chk("mid_rst_cnt", 32'(fcnt8), 0);
        @(negedge clk);
        rst = 1'b0;
        bc = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (busy8 || done8) bc++;
        end
        chk("mid_idle", 32'(bc), 0);

        scan_model(8, cnt, first, fidx, last);
        run8(1'b1, 8'd0, 8'd0, 1'b0, lat, bc);
        chk("rescan_lat", 32'(lat), 66);
        chk("rescan_cnt", 32'(fcnt8), 32'(cnt));
        chk("rescan_vec", 32'(fvec8), 32'(first));
        chk("rescan_idx", 32'(fidx8), 32'(fidx));
        chk("rescan_sum", 32'(sum8), 32'(last));

        // start held high through DIRECT, DONE and into IDLE.
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0;
        @(posedge clk);
        dmask = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (done8) begin
                dmask = dmask | (1 << n);
                if (n == 2) chk("hold_sum1", 32'(sum8), 7);
                if (n == 5) chk("hold_sum2", 32'(sum8), 9);
            end
            if (n == 2) a8 = 8'd5;
            start8 = (n <= 3);
        end
        start8 = 1'b0;
        chk("hold_done_mask", 32'(dmask), 32'((1 << 2) | (1 << 5)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_fault_scan.md
# adder_fault_scan

Parametrised ripple-carry adder with built-in self-test for locating faulty full-adder slices. It holds a WIDTH-bit chain of full-adder slices, evaluates single operations on request, and in scan mode sweeps every slice through all eight (a, b, carry-in) combinations. Each DUT result is compared against a behavioural golden sum, and the bench reads back the lowest faulty bit position and a fail count. It replaces the fixed 8-bit, plusarg-driven adder harness as the unit under test in the fault-localisation flow.

## Interface
- `WIDTH`, 8: operand width in bits, minimum 2.
- `FAULT_BIT`, 4: index of the slice replaced by the faulty model when fault injection is compiled in; range 0..WIDTH-1.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  1  sampled with `start`: 0 = direct, 1 = scan.
- `a`, `b`  in  WIDTH  direct-mode operands; sampled with `start`.
- `cin`  in  1  direct-mode carry-in; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse when results are valid.
- `sum`  out  WIDTH+1  DUT result of the most recent vector.
- `mismatch`  out  1  direct mode: DUT ≠ golden. Scan mode: any vector failed.
- `fault_idx`  out  $clog2(WIDTH)  lowest differing bit of the first failing vector.
- `fail_vec`  out  $clog2(8*WIDTH)  index of the first failing vector.
- `fail_count`  out  $clog2(8*WIDTH+1)  number of failing vectors.

## Operation
- States: IDLE, DIRECT, SCAN, FLUSH, DONE.
- IDLE + `start`: latch operands, clear `mismatch`, `fault_idx`, `fail_vec` and `fail_count`.
  - Go to DIRECT (mode 0) or SCAN (mode 1).
  - `start` is ignored in every other state.
- DIRECT: apply latched A, B, CIN to the slice chain; register `sum` and the compare result. Next state is DONE.
- Golden result: A + B + CIN computed at WIDTH+1 bits. Difference vector: D = DUT ^ golden.
- `fault_idx` is the lowest set bit of D.
- SCAN vector k, for k = 0..8*WIDTH-1:
  - Bit under test: i = k / 8. Combination {c, bb, aa} = k % 8 (`aa` is the LSB).
  - A = aa<<i. B = bb<<i.
  - If i > 0: CIN = 0, and c is produced by additionally setting bit i-1 in both A and B.
  - If i = 0: CIN = c.
- Vectors are applied one per cycle. The compare for vector k is registered in the cycle vector k+1 is applied.
- After the last vector, go to FLUSH for one cycle to record the final compare, then DONE.
- On each failing vector: `fail_count` increments (saturating).
  - The first failure latches `fault_idx` and `fail_vec` and sets `mismatch`.
  - Later failures do not overwrite `fault_idx` or `fail_vec`.
- DONE: pulse `done` and drop `busy`. Next state is IDLE.
- All outputs hold their values until the next accepted `start`.

## Timing
- Reset value of every output is 0. State returns to IDLE.
- Reset mid-scan aborts immediately; partial results are discarded.
- Direct latency: `start` sampled at edge 0, `done` high in cycle 2, `busy` high in cycle 1 only.
- Scan latency: `start` at edge 0, `done` high in cycle 8*WIDTH+2.
- `start` asserted in the same cycle as `done`: ignored, because the state is not yet IDLE.
- Arithmetic: no overflow; the carry-out lands in `sum[WIDTH]`.
- `fail_count` saturates at 8*WIDTH. It cannot wrap.

## Configuration
- `FAULT_INJECT_EN` defined: slice `FAULT_BIT` becomes the faulty model.
  - Faulty sum = a ^ b (carry-in ignored).
  - Carry-out stays correct: (a&b) | (cin&(a^b)).
- `FAULT_INJECT_EN` undefined: all slices are correct. Scan must end with `mismatch`=0 and `fail_count`=0.

## Test plan
- No macro, WIDTH=8, direct A=200, B=100, CIN=1 -> `sum`=301, `mismatch`=0, `done` in cycle 2.
- Macro, WIDTH=8, FAULT_BIT=4, direct A=8, B=8, CIN=0 -> `sum`=0, `mismatch`=1, `fault_idx`=4.
- Macro, WIDTH=8, FAULT_BIT=4, scan -> `fail_vec`=27, `fault_idx`=4, `fail_count`=8, `done` in cycle 66.
- No macro, WIDTH=16, scan -> `mismatch`=0, `fail_count`=0, `done` in cycle 130.
- Macro, scan, `rst` pulsed at cycle 20 -> all outputs 0, state IDLE; a new `start` runs a full scan with identical results.
- `start` held high across DIRECT and into DONE -> exactly one operation completes; a new operation starts only once the state is back in IDLE.
